reg_word_demux_layer: RTL and testbench

- Registered word demultiplexer/gather layer: the inverse of the word mux layer.
- Each accepted narrow beat carries WORDS_IN words plus a phase select.
- Input word i is written into output slot i*N_TO_1+sel of a wide register bank.
- Once all N_TO_1 phases of a frame are captured, the full WORDS_OUT-word frame is presented with a valid/ready handshake.
- Sits on the return path of muxed datapaths, rebuilding wide buses from time-multiplexed narrow ones.

---
 rtl/reg_word_demux_layer_pkg.sv | 36 +++
 rtl/reg_word_demux_layer_if.sv | 29 ++
 rtl/reg_word_demux_layer_word.sv | 39 +++
 rtl/reg_word_demux_layer.sv | 102 ++++++++++
 tb/tb_reg_word_demux_layer.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/reg_word_demux_layer_pkg.sv
// rtl/reg_word_demux_layer_pkg.sv - shared word mux/demux width formulas and index helpers
package reg_word_demux_layer_pkg;

    // Upper bound on phase select width; one-hot helpers return this many phases
    localparam int MAX_SEL_NUM = 6;
    localparam int MAX_PHASES  = 1 << MAX_SEL_NUM;

    // Phases per frame for a given select width
    function automatic int n_to_1(input int sel_num);
        return 1 << sel_num;
    endfunction

    // Words carried by each narrow beat
    function automatic int words_in(input int words_out, input int sel_num);
        return words_out >> sel_num;
    endfunction

    // Physical width of the sel port; a zero-width select still needs one wire
    function automatic int sel_w(input int sel_num);
        return (sel_num > 0) ? sel_num : 1;
    endfunction

    // Wide-frame slot that input word i lands in for phase sel
    function automatic int slot_idx(input int i, input int sel, input int phases);
        return i * phases + sel;
    endfunction

    // One-hot phase mask; callers keep only their low N_TO_1 bits
    function automatic logic [MAX_PHASES-1:0] onehot(input logic [MAX_SEL_NUM-1:0] idx);
        logic [MAX_PHASES-1:0] mask;
        mask      = '0;
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/reg_word_demux_layer_if.sv
// rtl/reg_word_demux_layer_if.sv - narrow beat in / wide frame out handshake bundle
interface reg_word_demux_layer_if
    import reg_word_demux_layer_pkg::*;
#(
    parameter int DWIDTH    = 32,
    parameter int WORDS_OUT = 32,
    parameter int SEL_NUM   = 2
);
    logic                                         clr;
    logic                                         ena;
    logic                                         rdy;
    logic [sel_w(SEL_NUM)-1:0]                    sel;
    logic [DWIDTH*words_in(WORDS_OUT,SEL_NUM)-1:0] din;
    logic [DWIDTH*WORDS_OUT-1:0]                  dout;
    logic                                         dout_vld;
    logic                                         dout_rdy;
    logic [n_to_1(SEL_NUM)-1:0]                   fill;
    logic                                         err_dup;

    modport master (
        output clr, ena, sel, din, dout_rdy,
        input  rdy, dout, dout_vld, fill, err_dup
    );

    modport slave (
        input  clr, ena, sel, din, dout_rdy,
        output rdy, dout, dout_vld, fill, err_dup
    );
endinterface

// File: rtl/reg_word_demux_layer_word.sv
// rtl/reg_word_demux_layer_word.sv - one input word steered into one of N_TO_1 slot registers
module reg_word_demux
    import reg_word_demux_layer_pkg::*;
#(
    parameter int DWIDTH  = 32,
    parameter int SEL_NUM = 2
)(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ena,
    input  logic [sel_w(SEL_NUM)-1:0]        sel,
    input  logic [DWIDTH-1:0]                din,
    output logic [DWIDTH*n_to_1(SEL_NUM)-1:0] dout
);
    localparam int N_TO_1 = n_to_1(SEL_NUM);

    logic [N_TO_1-1:0][DWIDTH-1:0] slot_d;
    logic [N_TO_1-1:0][DWIDTH-1:0] slot_q;

    // Only the selected slot takes the new word; the rest hold
    always_comb begin
        slot_d = slot_q;
        if (ena) begin
            slot_d[sel] = din;
        end
    end

    // Slot bank register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign dout = slot_q;

endmodule

// File: rtl/reg_word_demux_layer.sv
// rtl/reg_word_demux_layer.sv - gathers N_TO_1 narrow phases into one held wide frame
module reg_word_demux_layer
    import reg_word_demux_layer_pkg::*;
#(
    parameter int DWIDTH    = 32,
    parameter int WORDS_OUT = 32,
    parameter int SEL_NUM   = 2
)(
    input  logic                  clk,
    input  logic                  rst,
    reg_word_demux_layer_if.slave bus
);
    localparam int N_TO_1   = n_to_1(SEL_NUM);
    localparam int WORDS_IN = words_in(WORDS_OUT, SEL_NUM);
    localparam int SEL_W    = sel_w(SEL_NUM);

    logic [SEL_W-1:0]              sel_eff;
    logic [MAX_SEL_NUM-1:0]        sel_ext;
    logic [MAX_PHASES-1:0]         oh_wide;
    logic                          oh_unused;
    logic [N_TO_1-1:0]             sel_oh;
    logic [N_TO_1-1:0]             fill_next;
    logic [N_TO_1-1:0]             fill_d;
    logic [N_TO_1-1:0]             fill_q;
    logic                          dout_vld_d;
    logic                          dout_vld_q;
    logic                          err_dup_d;
    logic                          err_dup_q;
    logic                          rdy;
    logic                          accept;
    logic                          complete;
    logic                          bank_we;
    logic [DWIDTH*WORDS_OUT-1:0]   bank;

    // A single-phase frame has nothing to select, so sel is forced to phase 0
    assign sel_eff   = (N_TO_1 == 1) ? '0 : bus.sel;
    assign sel_ext   = {{(MAX_SEL_NUM-SEL_W){1'b0}}, sel_eff};
    assign oh_wide   = onehot(sel_ext);
    assign oh_unused = ^oh_wide[MAX_PHASES-1:N_TO_1];
    assign sel_oh    = oh_wide[N_TO_1-1:0];

    // Downstream consuming the held frame frees the bank in the same cycle
    assign rdy       = !dout_vld_q || bus.dout_rdy;
    assign accept    = bus.ena && rdy;
    assign fill_next = fill_q | sel_oh;
    assign complete  = &fill_next;
    assign bank_we   = accept && !bus.clr;

    // Frame tracking: fill mask, frame-valid and duplicate-phase pulse
    always_comb begin
        fill_d     = fill_q;
        dout_vld_d = dout_vld_q && !bus.dout_rdy;
        err_dup_d  = 1'b0;
        if (bus.clr) begin
            fill_d     = '0;
            dout_vld_d = 1'b0;
        end else if (accept) begin
            if (complete) begin
                fill_d     = '0;
                dout_vld_d = 1'b1;
            end else begin
                fill_d    = fill_next;
                err_dup_d = |(fill_q & sel_oh);
            end
        end
    end

    // Frame state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q     <= '0;
            dout_vld_q <= 1'b0;
            err_dup_q  <= 1'b0;
        end else begin
            fill_q     <= fill_d;
            dout_vld_q <= dout_vld_d;
            err_dup_q  <= err_dup_d;
        end
    end

    // Input word i owns the contiguous slot group i*N_TO_1 .. i*N_TO_1+N_TO_1-1
    for (genvar i = 0; i < WORDS_IN; i++) begin : g_word
        reg_word_demux #(
            .DWIDTH  (DWIDTH),
            .SEL_NUM (SEL_NUM)
        ) u_word (
            .clk  (clk),
            .rst  (rst),
            .ena  (bank_we),
            .sel  (sel_eff),
            .din  (bus.din[DWIDTH*i +: DWIDTH]),
            .dout (bank[DWIDTH*slot_idx(i, 0, N_TO_1) +: DWIDTH*N_TO_1])
        );
    end

    assign bus.rdy      = rdy;
    assign bus.dout     = bank;
    assign bus.dout_vld = dout_vld_q;
    assign bus.fill     = fill_q;
    assign bus.err_dup  = err_dup_q;

endmodule

// File: tb/tb_reg_word_demux_layer.sv
// tb/tb_reg_word_demux_layer.sv - directed self-checking bench for reg_word_demux_layer
module tb_reg_word_demux_layer;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    reg_word_demux_layer_if #(.DWIDTH(8), .WORDS_OUT(8), .SEL_NUM(2)) ifa ();
    reg_word_demux_layer_if #(.DWIDTH(8), .WORDS_OUT(2), .SEL_NUM(0)) ifb ();

    reg_word_demux_layer #(.DWIDTH(8), .WORDS_OUT(8), .SEL_NUM(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    reg_word_demux_layer #(.DWIDTH(8), .WORDS_OUT(2), .SEL_NUM(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [1:0] s, input logic [15:0] d);
        ifa.sel = s;
        ifa.din = d;
        ifa.ena = 1'b1;
        step();
        ifa.ena = 1'b0;
    endtask

    function automatic logic [15:0] std_din(input int s);
        return 16'h2010 + 16'(16'h0101 * s);
    endfunction

    localparam logic [63:0] STD_FRAME = 64'h2322212013121110;
    logic [1:0] ooo [4] = '{2'd2, 2'd0, 2'd3, 2'd1};

    initial begin
        rst          = 1'b1;
        ifa.clr      = 1'b0;
        ifa.ena      = 1'b0;
        ifa.sel      = '0;
        ifa.din      = '0;
        ifa.dout_rdy = 1'b0;
        ifb.clr      = 1'b0;
        ifb.ena      = 1'b0;
        ifb.sel      = '0;
        ifb.din      = '0;
        ifb.dout_rdy = 1'b0;
        repeat (2) step();

        chk("reset_dout", ifa.dout, 64'h0);
        chk("reset_vld", ifa.dout_vld, 1'b0);
        chk("reset_fill", ifa.fill, 4'b0000);
        chk("reset_err", ifa.err_dup, 1'b0);
        chk("reset_rdy", ifa.rdy, 1'b1);
        rst = 1'b0;
        step();

        // in-order fill
        ifa.dout_rdy = 1'b1;
        for (int s = 0; s < 4; s++) begin
            beat(2'(s), std_din(s));
            if (s == 2) begin
                chk("inorder_fill3", ifa.fill, 4'b0111);
                chk("inorder_vld_early", ifa.dout_vld, 1'b0);
            end
        end
        chk("inorder_vld", ifa.dout_vld, 1'b1);
        chk("inorder_fill0", ifa.fill, 4'b0000);
        chk("inorder_dout", ifa.dout, STD_FRAME);
        step();
        chk("inorder_vld_drop", ifa.dout_vld, 1'b0);

        // out-of-order fill
        for (int k = 0; k < 4; k++) begin
            beat(ooo[k], std_din(int'(ooo[k])));
            if (k == 1) chk("ooo_fill2", ifa.fill, 4'b0101);
            if (k == 2) chk("ooo_vld_early", ifa.dout_vld, 1'b0);
        end
        chk("ooo_vld", ifa.dout_vld, 1'b1);
        chk("ooo_dout", ifa.dout, STD_FRAME);
        step();
        chk("ooo_vld_drop", ifa.dout_vld, 1'b0);

        // backpressure
        ifa.dout_rdy = 1'b0;
        for (int s = 0; s < 4; s++) begin
            beat(2'(s), 16'h4030 + 16'(16'h0101 * s));
        end
        ifa.sel = 2'd2;
        ifa.din = 16'h5566;
        ifa.ena = 1'b1;
        #1;
        chk("bp_rdy_low", ifa.rdy, 1'b0);
        for (int c = 0; c < 5; c++) begin
            step();
            chk("bp_rdy_hold", ifa.rdy, 1'b0);
            chk("bp_vld_hold", ifa.dout_vld, 1'b1);
            chk("bp_dout_hold", ifa.dout, 64'h4342414033323130);
        end
        ifa.dout_rdy = 1'b1;
        #1;
        chk("bp_rdy_release", ifa.rdy, 1'b1);
        step();
        ifa.ena = 1'b0;
        chk("bp_vld_drain", ifa.dout_vld, 1'b0);
        chk("bp_fill_next", ifa.fill, 4'b0100);
        chk("bp_dout_next", ifa.dout, 64'h4355414033663130);

        // clr discards the partial frame
        ifa.clr = 1'b1;
        step();
        ifa.clr = 1'b0;
        chk("clr_fill", ifa.fill, 4'b0000);

        // duplicate phase
        beat(2'd1, 16'hBBAA);
        chk("dup_fill_first", ifa.fill, 4'b0010);
        chk("dup_err_first", ifa.err_dup, 1'b0);
        beat(2'd1, 16'hDDCC);
        chk("dup_err", ifa.err_dup, 1'b1);
        chk("dup_fill", ifa.fill, 4'b0010);
        chk("dup_slot1", ifa.dout[15:8], 8'hCC);
        chk("dup_slot5", ifa.dout[47:40], 8'hDD);
        step();
        chk("dup_err_pulse", ifa.err_dup, 1'b0);
        ifa.clr = 1'b1;
        step();
        ifa.clr = 1'b0;

        // abort with clr then refill
        beat(2'd0, std_din(0));
        beat(2'd1, std_din(1));
        chk("abort_fill_pre", ifa.fill, 4'b0011);
        ifa.clr = 1'b1;
        step();
        ifa.clr = 1'b0;
        chk("abort_fill", ifa.fill, 4'b0000);
        chk("abort_vld", ifa.dout_vld, 1'b0);
        for (int s = 0; s < 4; s++) begin
            beat(2'(s), std_din(s));
            if (s == 2) chk("abort_vld_early", ifa.dout_vld, 1'b0);
        end
        chk("abort_refill_vld", ifa.dout_vld, 1'b1);
        chk("abort_refill_dout", ifa.dout, STD_FRAME);
        step();

        // asynchronous reset mid-frame
        beat(2'd0, std_din(0));
        beat(2'd1, std_din(1));
        #2 rst = 1'b1;
        #1;
        chk("arst_fill", ifa.fill, 4'b0000);
        chk("arst_dout", ifa.dout, 64'h0);
        #1 rst = 1'b0;
        for (int s = 0; s < 4; s++) begin
            beat(2'(s), std_din(s));
            if (s == 0) chk("arst_fresh_fill", ifa.fill, 4'b0001);
        end
        chk("arst_refill_vld", ifa.dout_vld, 1'b1);
        chk("arst_refill_dout", ifa.dout, STD_FRAME);
        ifa.dout_rdy = 1'b0;
        step();
        chk("arst_held_vld", ifa.dout_vld, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst_vld_drop", ifa.dout_vld, 1'b0);
        chk("arst_dout_drop", ifa.dout, 64'h0);
        #1 rst = 1'b0;
        ifa.dout_rdy = 1'b1;

        // single-phase pass-through
        ifb.dout_rdy = 1'b1;
        ifb.ena      = 1'b1;
        ifb.din      = 16'h0102;
        step();
        chk("pt_vld_1", ifb.dout_vld, 1'b1);
        chk("pt_dout_1", ifb.dout, 16'h0102);
        ifb.din = 16'h0304;
        step();
        chk("pt_vld_2", ifb.dout_vld, 1'b1);
        chk("pt_dout_2", ifb.dout, 16'h0304);
        ifb.din = 16'h0506;
        step();
        chk("pt_dout_3", ifb.dout, 16'h0506);
        ifb.ena = 1'b0;
        step();
        chk("pt_vld_drop", ifb.dout_vld, 1'b0);
        chk("pt_dout_keep", ifb.dout, 16'h0506);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
